// File: rtl/shake256_squeeze.sv
// SHAKE256 squeeze stage: serialises 1088-bit rate blocks into 64-bit output words,
// truncates the stream to a requested bit length and requests further permutations.
module shake256_squeeze (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   out_len,
    input  logic [1087:0] blk_data,
    input  logic          blk_valid,
    output logic          blk_ready,
    output logic          perm_req,
    output logic [63:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [6:0]    dout_nbits,
    output logic          dout_last,
    output logic          busy,
    output logic          done
);

    localparam logic [4:0] LAST_WORD_IDX = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLK,
        EMIT,
        REQ
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [15:0]     rem;
    logic [4:0]      word_idx;
    logic [1087:0]   blk_buf;
    logic            done_q;

    logic            final_word;
    logic [6:0]      nbits_cur;
    logic [63:0]     keep_mask;

    // Every output below is decoded from registers only, so no input reaches an output
    // within the same cycle.
    assign final_word = (rem <= 16'd64);
    assign nbits_cur  = final_word ? rem[6:0] : 7'd64;
    assign keep_mask  = {64{1'b1}} << (7'd64 - nbits_cur);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of the order of statements or blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that leaves one
    // unassigned would infer a latch.
    always_comb begin
        state_next = state;
        blk_ready  = 1'b0;
        perm_req   = 1'b0;
        dout_valid = 1'b0;
        dout       = '0;
        dout_nbits = '0;
        dout_last  = 1'b0;
        busy       = (state != IDLE);
        done       = done_q;

        case (state)
            IDLE: begin
                if (start && (out_len != 16'd0)) begin
                    state_next = WAIT_BLK;
                end
            end
            WAIT_BLK: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                dout_valid = 1'b1;
                dout       = blk_buf[1087:1024] & keep_mask;
                dout_nbits = nbits_cur;
                dout_last  = final_word;
                if (dout_ready) begin
                    if (final_word) begin
                        state_next = IDLE;
                    end else if (word_idx == LAST_WORD_IDX) begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                perm_req   = 1'b1;
                state_next = WAIT_BLK;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: the block buffer is an ordinary register, not a RAM, so it is cleared on
    // reset like everything else; no stale key-derived data survives a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            word_idx <= '0;
            blk_buf  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (out_len == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            rem      <= out_len;
                            word_idx <= '0;
                        end
                    end
                end
                WAIT_BLK: begin
                    if (blk_valid) begin
                        blk_buf  <= blk_data;
                        word_idx <= '0;
                    end
                end
                EMIT: begin
                    if (dout_ready) begin
                        if (final_word) begin
                            done_q <= 1'b1;
                        end else begin
                            // rem > 64 here, so the subtraction cannot wrap.
                            rem <= rem - 16'd64;
                            if (word_idx != LAST_WORD_IDX) begin
                                blk_buf  <= blk_buf << 64;
                                word_idx <= word_idx + 5'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shake256_squeeze.sv
// Directed, table-driven bench for shake256_squeeze with a small word-stream model
// and hand-written sequences for zero length and mid-squeeze reset.
module tb_shake256_squeeze;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   out_len;
    logic [1087:0] blk_data;
    logic          blk_valid;
    logic          blk_ready;
    logic          perm_req;
    logic [63:0]   dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [6:0]    dout_nbits;
    logic          dout_last;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shake256_squeeze dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .out_len    (out_len),
        .blk_data   (blk_data),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .perm_req   (perm_req),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_nbits (dout_nbits),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [15:0] out_len;
        int          pat;
        bit          rand_rdy;
        bit          inject;
        int          exp_words;
        int          exp_perms;
        int          exp_nbits;
        logic [63:0] exp_last_word;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] blk_word(input int pat, input int b, input int k);
        logic [63:0] w;
        case (pat)
            0:       w = (64'(b) << 56) | (64'(k) << 4) | 64'(k);
            1:       w = '1;
            default: w = {16'hA5C3, 8'(b), 8'(k), 32'h1357_9BDF ^ (32'(k) * 32'h0101_0101)};
        endcase
        return w;
    endfunction

    function automatic logic [1087:0] make_block(input int pat, input int b);
        logic [1087:0] blk;
        blk = '0;
        for (int k = 0; k < 17; k++) begin
            blk[1087 - 64 * k -: 64] = blk_word(pat, b, k);
        end
        return blk;
    endfunction

    function automatic logic [63:0] keep_top(input logic [63:0] w, input int nb);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < nb) r[63 - i] = w[63 - i];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_case(input vec_t v);
        int          words_out   = 0;
        int          perms       = 0;
        int          blks        = 0;
        int          cyc         = 0;
        int          last_nbits  = -1;
        bit          finished    = 1'b0;
        bit          expect_done = 1'b0;
        bit          expect_perm = 1'b0;
        bit          expect_brdy = 1'b0;
        bit          stalled     = 1'b0;
        bit          rdy;
        bit          hs;
        bit          nxt_perm;
        logic [63:0] prev_dout   = '0;
        logic [6:0]  prev_nbits  = '0;
        logic        prev_last   = 1'b0;
        logic [63:0] last_word   = '0;
        int          rem_i;
        int          exp_nb;
        bit          exp_last;
        int          k;

        start     = 1'b1;
        out_len   = v.out_len;
        blk_valid = 1'b1;
        blk_data  = make_block(v.pat, 0);
        tick();
        start = 1'b0;

        while (!finished && cyc < 3000) begin
            cyc++;
            start = 1'b0;
            if (expect_done) begin
                check("done_after_last", done, 1'b1);
                check("busy_after_last", busy, 1'b0);
                check("valid_after_last", dout_valid, 1'b0);
                finished = 1'b1;
            end else begin
                if (expect_perm) check("perm_req_timing", perm_req, 1'b1);
                if (expect_brdy) check("blk_ready_timing", blk_ready, 1'b1);
                if (perm_req) perms++;
                check("no_early_done", done, 1'b0);
                blk_data = make_block(v.pat, blks);
                if (blk_ready) blks++;

                rem_i    = int'(v.out_len) - 64 * words_out;
                exp_nb   = (rem_i >= 64) ? 64 : rem_i;
                exp_last = (rem_i <= 64);
                k        = words_out % 17;
                rdy      = v.rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                hs       = 1'b0;
                nxt_perm = 1'b0;
                if (dout_valid) begin
                    check("dout", dout, keep_top(blk_word(v.pat, words_out / 17, k), exp_nb));
                    check("dout_nbits", dout_nbits, 64'(exp_nb));
                    check("dout_last", dout_last, exp_last);
                    if (stalled) begin
                        check("stall_hold_dout", dout, prev_dout);
                        check("stall_hold_nbits", dout_nbits, prev_nbits);
                        check("stall_hold_last", dout_last, prev_last);
                    end
                    if (v.inject && words_out == 1) begin
                        start   = 1'b1;
                        out_len = 16'hFFFF;
                    end
                    hs = rdy;
                    if (hs) begin
                        words_out++;
                        nxt_perm = (k == 16) && !exp_last;
                        if (exp_last) begin
                            expect_done = 1'b1;
                            last_word   = dout;
                            last_nbits  = int'(dout_nbits);
                        end
                    end
                end
                dout_ready  = rdy;
                stalled     = dout_valid && !rdy;
                prev_dout   = dout;
                prev_nbits  = dout_nbits;
                prev_last   = dout_last;
                expect_brdy = expect_perm;
                expect_perm = nxt_perm;
                tick();
            end
        end

        check("finished_in_budget", 64'(finished), 64'd1);
        check("word_count", 64'(words_out), 64'(v.exp_words));
        check("perm_count", 64'(perms), 64'(v.exp_perms));
        check("last_word", last_word, v.exp_last_word);
        check("last_nbits", 64'(last_nbits), 64'(v.exp_nbits));
        start = 1'b0;
        tick();
        check("done_is_pulse", done, 1'b0);
    endtask

    vec_t vecs[9];
    vec_t v_short;
    bit   found;

    initial begin
        vecs[0] = '{16'd256,  0, 1'b0, 1'b0,  4, 0, 64, 64'h0000_0000_0000_0033};
        vecs[1] = '{16'd2176, 0, 1'b0, 1'b0, 34, 1, 64, 64'h0100_0000_0000_0110};
        vecs[2] = '{16'd100,  1, 1'b0, 1'b0,  2, 0, 36, 64'hFFFF_FFFF_F000_0000};
        vecs[3] = '{16'd512,  0, 1'b1, 1'b0,  8, 0, 64, 64'h0000_0000_0000_0077};
        vecs[4] = '{16'd1088, 2, 1'b0, 1'b0, 17, 0, 64, 64'hA5C3_0010_0347_8BCF};
        vecs[5] = '{16'd1,    1, 1'b0, 1'b0,  1, 0,  1, 64'h8000_0000_0000_0000};
        vecs[6] = '{16'd1100, 1, 1'b1, 1'b0, 18, 1, 12, 64'hFFF0_0000_0000_0000};
        vecs[7] = '{16'd256,  0, 1'b0, 1'b1,  4, 0, 64, 64'h0000_0000_0000_0033};
        vecs[8] = '{16'd3300, 2, 1'b1, 1'b0, 52, 3, 36, 64'hA5C3_0300_1000_0000};
        v_short = '{16'd64,   0, 1'b0, 1'b0,  1, 0, 64, 64'h0000_0000_0000_0000};

        rst        = 1'b1;
        start      = 1'b0;
        out_len    = '0;
        blk_data   = '0;
        blk_valid  = 1'b0;
        dout_ready = 1'b0;
        repeat (3) tick();
        check("rst_blk_ready", blk_ready, 1'b0);
        check("rst_perm_req", perm_req, 1'b0);
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_dout", dout, 64'd0);
        check("rst_dout_nbits", dout_nbits, 64'd0);
        check("rst_dout_last", dout_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_case(vecs[i]);

        // Zero-length request completes immediately without leaving IDLE.
        out_len = 16'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_blk_ready", blk_ready, 1'b0);
        check("zero_dout_valid", dout_valid, 1'b0);
        tick();
        check("zero_done_pulse", done, 1'b0);
        check("zero_busy_after", busy, 1'b0);

        // Reset while word 5 is presented.
        out_len    = 16'd2176;
        blk_valid  = 1'b1;
        blk_data   = make_block(0, 0);
        dout_ready = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (dout_valid && dout == blk_word(0, 0, 5)) found = 1'b1;
            else tick();
        end
        check("reached_word5", 64'(found), 64'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_dout_valid", dout_valid, 1'b0);
        check("mid_rst_dout", dout, 64'd0);
        check("mid_rst_nbits", dout_nbits, 64'd0);
        check("mid_rst_last", dout_last, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_blk_ready", blk_ready, 1'b0);
        check("mid_rst_perm_req", perm_req, 1'b0);
        rst = 1'b0;
        tick();
        check("post_rst_done", done, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        run_case(v_short);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shake256_squeeze.md
# shake256_squeeze

Output (squeeze) stage of the SHAKE256 core, the counterpart of the input padder. It accepts 1088-bit rate blocks from the Keccak permutation, using the padder's byte order (byte 0 at bits [1087:1080]). It serialises them into 64-bit output words with a valid/ready handshake, truncates the stream to a requested bit length, and requests further permutations when one rate block is exhausted.

## Interface
Parameters:
- none; rate fixed at 1088 bits (17 words of 64 bits).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin squeeze; sampled only in IDLE.
- out_len  input  16  requested output length in bits; latched on accepted start.
- blk_data  input  1088  rate portion of Keccak state, byte 0 at [1087:1080].
- blk_valid  input  1  blk_data valid.
- blk_ready  output  1  block accepted when blk_valid && blk_ready.
- perm_req  output  1  one-cycle pulse requesting the next permutation.
- dout  output  64  output word; first byte at [63:56].
- dout_valid  output  1  dout valid.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
- dout_nbits  output  7  valid MSB-aligned bits in dout, 1..64.
- dout_last  output  1  final word of the squeeze.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse on completion.

## Operation
- States: IDLE, WAIT_BLK, EMIT, REQ.
- IDLE:
  - start with out_len != 0: latch rem = out_len, clear word_idx, go to WAIT_BLK.
  - start with out_len == 0: pulse done next cycle, stay IDLE.
- WAIT_BLK: blk_ready = 1. On blk_valid, load blk_data into the 1088-bit shift buffer, word_idx = 0, go to EMIT.
- EMIT:
  - dout_valid = 1; dout = buf[1087:1024] masked to the top dout_nbits bits (lower bits forced 0).
  - dout_nbits = min(64, rem); dout_last = (rem <= 64).
- On an EMIT handshake:
  - If rem <= 64: go to IDLE and pulse done.
  - Else if word_idx == 16: rem -= 64, go to REQ.
  - Else: rem -= 64, shift buf left by 64, increment word_idx.
- REQ: perm_req = 1 for exactly one cycle, then go to WAIT_BLK.
- The first block needs no perm_req; the absorb side supplies it from its final permutation.
- Arithmetic: rem is 16 bits wide and never underflows; subtraction happens only when rem > 64.
- Boundaries:
  - start while busy: ignored.
  - blk_valid outside WAIT_BLK: ignored (blk_ready = 0).
  - dout_ready high while dout_valid is low: no effect.
  - out_len an exact multiple of 1088: the final word of the last block has dout_last = 1 and issues no perm_req.
  - rst at any time, including mid-EMIT or mid-REQ: next state IDLE; rem, word_idx and buffer cleared; no done pulse.

## Timing
- Reset values: blk_ready, perm_req, dout_valid, dout_last, busy and done are 0; dout = 0; dout_nbits = 0.
- Block accepted at cycle t: dout_valid = 1 at t+1.
- With dout_ready held high, one word per cycle; 17 words of a block take 17 consecutive cycles.
- Handshake of word 16 at t: perm_req = 1 at t+1, blk_ready = 1 from t+2.
- Final handshake at t: at t+1, done = 1, busy = 0, dout_valid = 0.
- start with out_len == 0 at t: done = 1 at t+1, busy stays 0.
- While dout_valid && !dout_ready, dout, dout_nbits and dout_last are held stable.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- **Single block, short output.** Block word k = 64'h0000_0000_0000_00k0 + k; out_len = 256; dout_ready high. Expect:
  - 4 words k = 0..3 on consecutive cycles, each with dout_nbits = 64;
  - dout_last on word 3 and done at the following cycle;
  - perm_req never asserted.
- **Multi-block.** out_len = 2176. Expect:
  - 17 words from block A;
  - a perm_req pulse 1 cycle after word 16 and blk_ready 2 cycles after;
  - 17 words from block B, dout_last on the 34th word, exactly one perm_req in total.
- **Partial word.** out_len = 100, block = all-ones. Expect:
  - word 0 = 64'hFFFF_FFFF_FFFF_FFFF with dout_nbits = 64;
  - word 1 = 64'hFFFF_FFFF_F000_0000 with dout_nbits = 36 and dout_last = 1.
- **Backpressure.** out_len = 512 with dout_ready toggling pseudo-randomly. Expect:
  - dout, dout_nbits and dout_last stable while stalled;
  - all 8 words in order, none dropped or duplicated.
- **Zero length and ignored start.**
  - out_len = 0: done at start + 1, while busy, blk_ready and dout_valid stay 0.
  - A second start during a squeeze does not change rem.
- **Reset mid-operation.** Assert rst during EMIT of word 5. Expect:
  - next cycle all outputs at reset values and no done pulse;
  - a fresh start with out_len = 64 then produces exactly one word with dout_last = 1.
